// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer site encoding, pipeline latency and the
// rounding averages reused by several ISP stages.
package isp_pkg;

    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_GR = 2'd1,
        PH_GB = 2'd2,
        PH_B  = 2'd3
    } bayer_ph_e;

    // CFA phase of the first pixel of a frame
    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_cfg_e;

    localparam int DLY_CLK = 4;
    localparam int SUM_W   = 16;

    function automatic logic [SUM_W-1:0] avg2(input logic [SUM_W-1:0] s);
        return (s + SUM_W'(1)) >> 1;
    endfunction

    function automatic logic [SUM_W-1:0] avg4(input logic [SUM_W-1:0] s);
        return (s + SUM_W'(2)) >> 2;
    endfunction

endpackage

// File: rtl/shift_register.sv
// Cascaded line delay: tap 0 is the input delayed by DEPTH accepted samples,
// each further tap adds another DEPTH. Read-first RAM per tap.
module shift_register #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1280,
    parameter int TAPS   = 2
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          en_i,
    input  logic [DATA_W-1:0]             din_i,
    output logic [TAPS-1:0][DATA_W-1:0]   tap_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
        // Later taps are fed from the registered read of the previous one,
        // which already carries one sample of delay.
        localparam int TAP_DEPTH = (gi == 0) ? DEPTH : DEPTH - 1;
        localparam logic [PTR_W-1:0] LAST = PTR_W'(TAP_DEPTH - 1);

        logic [DATA_W-1:0] mem [TAP_DEPTH];
        logic [PTR_W-1:0]  ptr_q;
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] wr_data;

        if (gi == 0) begin : g_head
            assign wr_data = din_i;
        end else begin : g_chain
            assign wr_data = tap_o[gi-1];
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                ptr_q <= '0;
            end else if (en_i) begin
                ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (en_i) begin
                rd_q       <= mem[ptr_q];
                mem[ptr_q] <= wr_data;
            end
        end

        assign tap_o[gi] = rd_q;
    end

endmodule

// File: rtl/isp_demosaic.sv
// Bilinear 3x3 Bayer-to-RGB demosaic. Output is centred one row and one
// column behind the incoming pixel, DLY_CLK cycles after it.
module isp_demosaic
    import isp_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 0
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic            in_de,
    input  logic [BITS-1:0] in_raw,
    output logic            out_href,
    output logic            out_vsync,
    output logic            out_de,
    output logic [BITS-1:0] out_r,
    output logic [BITS-1:0] out_g,
    output logic [BITS-1:0] out_b
);

    if (WIDTH < 3 || HEIGHT < 3) begin : g_bad_geometry
        $error("isp_demosaic: frame must be at least 3x3");
    end

    localparam logic [1:0] BAYER_PH = 2'(BAYER);

    // After a reset the stream is ignored until a frame boundary re-aligns it
    logic frame_ok_q, frame_ok_d;
    logic href_g, de_g;
    assign frame_ok_d = frame_ok_q | in_vsync;
    assign href_g     = in_href & frame_ok_d;
    assign de_g       = in_de & frame_ok_d;

    logic odd_pix_q, odd_line_q, href_prev_q;
    logic [1:0] fmt_q [2];
    logic [1:0] fmt_d;
    // Centre sits one line and one pixel behind the input, so both parities flip
    assign fmt_d = BAYER_PH ^ {~odd_line_q, ~odd_pix_q};

    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_ok_q  <= 1'b0;
            odd_pix_q   <= 1'b0;
            odd_line_q  <= 1'b0;
            href_prev_q <= 1'b0;
            fmt_q[0]    <= '0;
            fmt_q[1]    <= '0;
        end else begin
            frame_ok_q  <= frame_ok_d;
            odd_pix_q   <= href_g ? ~odd_pix_q : 1'b0;
            href_prev_q <= href_g;
            if (in_vsync) begin
                odd_line_q <= 1'b0;
            end else if (href_prev_q && !href_g) begin
                odd_line_q <= ~odd_line_q;
            end
            fmt_q[0] <= fmt_d;
            fmt_q[1] <= fmt_q[0];
        end
    end

    // Sync delay line: {href, vsync, de}
    logic [2:0] sync_q [DLY_CLK];
    always_ff @(posedge pclk) begin
        if (rst) sync_q[0] <= '0;
        else     sync_q[0] <= {href_g, in_vsync, de_g};
    end
    for (genvar gi = 1; gi < DLY_CLK; gi++) begin : g_sync
        always_ff @(posedge pclk) begin
            if (rst) sync_q[gi] <= '0;
            else     sync_q[gi] <= sync_q[gi-1];
        end
    end

    logic [BITS-1:0] raw_q;
    logic [1:0][BITS-1:0] line_taps;

    always_ff @(posedge pclk) begin
        if (rst) raw_q <= '0;
        else     raw_q <= in_raw;
    end

    shift_register #(
        .DATA_W (BITS),
        .DEPTH  (WIDTH),
        .TAPS   (2)
    ) u_line_buf (
        .clk   (pclk),
        .srst  (rst),
        .en_i  (href_g),
        .din_i (in_raw),
        .tap_o (line_taps)
    );

    // Window rows: 0 = two lines back, 1 = previous line (centre), 2 = current
    logic [BITS-1:0] win_q [3][3];
    logic [BITS-1:0] col_in [3];
    assign col_in[0] = line_taps[1];
    assign col_in[1] = line_taps[0];
    assign col_in[2] = raw_q;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        always_ff @(posedge pclk) begin
            if (rst) begin
                win_q[gi][0] <= '0;
                win_q[gi][1] <= '0;
                win_q[gi][2] <= '0;
            end else begin
                win_q[gi][0] <= win_q[gi][1];
                win_q[gi][1] <= win_q[gi][2];
                win_q[gi][2] <= col_in[gi];
            end
        end
    end

    logic [BITS:0]   h_sum, v_sum;
    logic [BITS+1:0] x_sum, nsew_sum;
    logic [BITS-1:0] centre, h_avg, v_avg, x_avg, nsew_avg;
    logic [BITS-1:0] r_d, g_d, b_d;

    assign centre   = win_q[1][1];
    assign h_sum    = {1'b0, win_q[1][0]} + {1'b0, win_q[1][2]};
    assign v_sum    = {1'b0, win_q[0][1]} + {1'b0, win_q[2][1]};
    assign x_sum    = {2'b0, win_q[0][0]} + {2'b0, win_q[0][2]}
                    + {2'b0, win_q[2][0]} + {2'b0, win_q[2][2]};
    assign nsew_sum = {1'b0, h_sum} + {1'b0, v_sum};
    assign h_avg    = BITS'(avg2(SUM_W'(h_sum)));
    assign v_avg    = BITS'(avg2(SUM_W'(v_sum)));
    assign x_avg    = BITS'(avg4(SUM_W'(x_sum)));
    assign nsew_avg = BITS'(avg4(SUM_W'(nsew_sum)));

    always_comb begin
        r_d = centre;
        g_d = nsew_avg;
        b_d = x_avg;
        case (bayer_ph_e'(fmt_q[1]))
            PH_R:  begin r_d = centre; g_d = nsew_avg; b_d = x_avg;  end
            PH_B:  begin r_d = x_avg;  g_d = nsew_avg; b_d = centre; end
            PH_GR: begin r_d = h_avg;  g_d = centre;   b_d = v_avg;  end
            PH_GB: begin r_d = v_avg;  g_d = centre;   b_d = h_avg;  end
            default: ;
        endcase
    end

    logic [BITS-1:0] rgb_q [3];
    logic [BITS-1:0] out_q [3];
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rgb_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            rgb_q[0] <= r_d;
            rgb_q[1] <= g_d;
            rgb_q[2] <= b_d;
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= sync_q[DLY_CLK-2][2] ? rgb_q[i] : '0;
            end
        end
    end

    assign out_href  = sync_q[DLY_CLK-1][2];
    assign out_vsync = sync_q[DLY_CLK-1][1];
    assign out_de    = sync_q[DLY_CLK-1][0];
    assign out_r     = out_q[0];
    assign out_g     = out_q[1];
    assign out_b     = out_q[2];

endmodule
